// File: rtl/sumu_pkg.sv
// Shared constants for the sudemux stream demultiplexer family.
package sumu_pkg;
  localparam int   SUMU_W        = 2;
  localparam logic ADDR_OUT0     = 1'b0;
  localparam logic ADDR_OUT1     = 1'b1;
  localparam int   SUDEMUX_DEPTH = 2;
endpackage

// File: rtl/sudemux_fifo.sv
// Per-output FIFO with extra-MSB pointers and a registered head word that holds
// its last value while empty.
module sudemux_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [W-1:0]  dout_q;
  logic          do_push, do_pop;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign dout    = dout_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // The head register is preloaded with whatever will sit at rd_nxt after
  // this edge; if that slot is the one being written now, take din directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      dout_q <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      if (rd_nxt != wr_nxt) begin
        if (do_push && (rd_nxt == wr_ptr)) dout_q <= din;
        else                               dout_q <= mem[rd_nxt[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/sudemux2.sv
// Two-output valid/ready demultiplexer steering each word to one of two FIFOs.
// Optional per-address accept counters when SUDEMUX_CNT_EN is defined.
module sudemux2
  import sumu_pkg::*;
#(
  parameter int W     = SUMU_W,
  parameter int DEPTH = SUDEMUX_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_addr,
  input  logic [W-1:0] in_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [W-1:0] out0_data,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [W-1:0] out1_data
`ifdef SUDEMUX_CNT_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
`endif
);
  logic full0, full1, empty0, empty1;
  logic push0, push1;

  assign in_ready   = !rst && !((in_addr == ADDR_OUT1) ? full1 : full0);
  assign push0      = in_valid && in_ready && (in_addr == ADDR_OUT0);
  assign push1      = in_valid && in_ready && (in_addr == ADDR_OUT1);
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  sudemux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .din   (in_data),
    .full  (full0),
    .pop   (out0_ready),
    .dout  (out0_data),
    .empty (empty0)
  );

  sudemux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   (in_data),
    .full  (full1),
    .pop   (out1_ready),
    .dout  (out1_data),
    .empty (empty1)
  );

`ifdef SUDEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + 8'd1;
      if (push1) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sudemux2.sv
// Randomized bench for sudemux2 against a queue-based reference model.
module tb_sudemux2;
  localparam int W     = 2;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_addr = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out0_valid, out1_valid;
  logic         out0_ready = 1'b0, out1_ready = 1'b0;
  logic [W-1:0] out0_data, out1_data;
`ifdef SUDEMUX_CNT_EN
  logic [7:0]   cnt0, cnt1;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] h0 = '0, h1 = '0;
  int           acc0 = 0, acc1 = 0;

  always #5 clk = ~clk;

  sudemux2 #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef SUDEMUX_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive, check against the model, then advance the model as the edge will.
  task automatic step(input logic v, input logic a, input logic [W-1:0] d,
                      input logic r0, input logic r1, input logic rs);
    logic exp_rdy;
    logic pop0, pop1;
    @(negedge clk);
    rst = rs; in_valid = v; in_addr = a; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    exp_rdy = !rs && ((a ? q1.size() : q0.size()) < DEPTH);
    chk("in_ready",   {31'd0, in_ready},   {31'd0, exp_rdy});
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() > 0});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() > 0});
    chk("out0_data",  32'(out0_data), 32'(h0));
    chk("out1_data",  32'(out1_data), 32'(h1));
`ifdef SUDEMUX_CNT_EN
    chk("cnt0", 32'(cnt0), 32'(acc0 % 256));
    chk("cnt1", 32'(cnt1), 32'(acc1 % 256));
`endif
    if (rs) begin
      q0.delete(); q1.delete();
      h0 = '0; h1 = '0; acc0 = 0; acc1 = 0;
    end else begin
      pop0 = r0 && (q0.size() > 0);
      pop1 = r1 && (q1.size() > 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (v && exp_rdy) begin
        if (a) begin q1.push_back(d); acc1++; end
        else   begin q0.push_back(d); acc0++; end
      end
      if (q0.size() > 0) h0 = q0[0];
      if (q1.size() > 0) h1 = q1[0];
    end
  endtask

  initial begin
    // Two reset edges before any checking, so DUT state is defined.
    repeat (2) @(posedge clk);

    step(0, 0, 2'd0, 0, 0, 0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_v0",    {31'd0, out0_valid}, 32'd0);
    chk("idle_d1",    32'(out1_data), 32'd0);

    // Steering
    step(1, 0, 2'b01, 0, 0, 0);
    step(1, 1, 2'b10, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0);
    chk("steer_d0", 32'(out0_data), 32'd1);
    chk("steer_d1", 32'(out1_data), 32'd2);
    step(0, 0, 2'd0, 1, 1, 0);

    // Backpressure on output 0 while output 1 keeps accepting
    step(1, 0, 2'd3, 0, 1, 0);
    step(1, 1, 2'd1, 0, 1, 0);
    step(1, 0, 2'd2, 0, 1, 0);
    step(1, 0, 2'd1, 0, 1, 0);
    chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    step(1, 1, 2'd2, 0, 1, 0);
    // Full with simultaneous pop: no push this cycle, then accepted next
    step(1, 0, 2'd1, 1, 1, 0);
    step(1, 0, 2'd1, 0, 1, 0);
    step(0, 0, 2'd0, 1, 1, 0);
    repeat (3) step(0, 0, 2'd0, 1, 1, 0);

    // Steady stream to addr 1 across pointer wrap
    for (int i = 0; i < 20; i++) step(1, 1, 2'(i % 4), 0, 1, 0);
    repeat (2) step(0, 0, 2'd0, 1, 1, 0);

    // Mid-stream reset with two words queued each side
    step(1, 0, 2'd1, 0, 0, 0);
    step(1, 0, 2'd2, 0, 0, 0);
    step(1, 1, 2'd3, 0, 0, 0);
    step(1, 1, 2'd0, 0, 0, 0);
    step(1, 0, 2'd3, 0, 0, 1);
    step(0, 0, 2'd0, 1, 1, 0);
    chk("rst_v0", {31'd0, out0_valid}, 32'd0);
    chk("rst_v1", {31'd0, out1_valid}, 32'd0);
    repeat (3) step(0, 0, 2'd0, 1, 1, 0);

    // Randomized phases with different consumer throttling
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             $urandom_range(0, 3) < ph + 1,
             $urandom_range(0, 3) < 4 - ph,
             $urandom_range(0, 99) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
